// File: rtl/cmp_tracker_pkg.sv
// ============================================================================
// Module      : cmp_tracker_pkg
// Description : Shared encodings and helpers for the comparator result
//               tracker: one-hot result codes, FSM state type, legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_tracker_pkg;

  // One-hot comparator result codes, bit2=lt, bit1=eq, bit0=gt
  localparam logic [2:0] RES_GT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  // A comparator result is legal only when exactly one class bit is set
  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == RES_GT) || (code == RES_EQ) || (code == RES_LT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. clr restarts the count; clr together
//               with inc restarts it at one (used to begin a new streak).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;

  // Count up on inc, hold at the maximum value instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= inc ? W'(1) : '0;
    end else if (inc && (cnt_q != C_MAX)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cmp_result_tracker.sv
// ============================================================================
// Module      : cmp_result_tracker
// Description : Statistics stage behind the 2-bit magnitude comparator.
//               Tracks per-class saturating counts, last legal result, streak
//               of identical results, change pulse and sticky illegal flag.
//               Optional total sample counter enabled by CMP_TRACKER_TOTAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_result_tracker
  import cmp_tracker_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STREAK_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_gt,
  input  logic                in_eq,
  input  logic                in_lt,
  input  logic                clear,
  input  logic                freeze,
  output logic [2:0]          last_res,
  output logic                last_valid,
  output logic [CNT_W-1:0]    gt_cnt,
  output logic [CNT_W-1:0]    eq_cnt,
  output logic [CNT_W-1:0]    lt_cnt,
  output logic [STREAK_W-1:0] streak,
  output logic                change_pulse,
  output logic                illegal,
`ifdef CMP_TRACKER_TOTAL_EN
  output logic [CNT_W+1:0]    total_cnt,
`endif
  output logic [1:0]          state
);

  state_e     state_q;
  logic [2:0] last_res_q;
  logic       last_valid_q;
  logic       change_q;
  logic       illegal_q;

  logic [2:0] code_w;
  logic       accept_w;
  logic       legal_w;
  logic       legal_acc_w;
  logic       illegal_acc_w;
  logic       same_w;
  logic       streak_clr_w;

  assign code_w        = {in_lt, in_eq, in_gt};
  // clear and freeze both drop a coincident sample; FROZEN drops it too
  assign accept_w      = in_valid && (state_q != FROZEN) && !freeze && !clear;
  assign legal_w       = is_onehot3(code_w);
  assign legal_acc_w   = accept_w && legal_w;
  assign illegal_acc_w = accept_w && !legal_w;
  assign same_w        = last_valid_q && (code_w == last_res_q);
  // A differing legal result restarts the streak at 1, an illegal one zeroes it
  assign streak_clr_w  = clear || illegal_acc_w || (legal_acc_w && !same_w);

  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(legal_acc_w && (code_w == RES_GT)), .cnt(gt_cnt)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(legal_acc_w && (code_w == RES_EQ)), .cnt(eq_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(legal_acc_w && (code_w == RES_LT)), .cnt(lt_cnt)
  );

  sat_counter #(.W(STREAK_W)) u_streak (
    .clk(clk), .rst(rst), .clr(streak_clr_w),
    .inc(legal_acc_w), .cnt(streak)
  );

`ifdef CMP_TRACKER_TOTAL_EN
  sat_counter #(.W(CNT_W + 2)) u_total_cnt (
    .clk(clk), .rst(rst), .clr(clear),
    .inc(accept_w), .cnt(total_cnt)
  );
`endif

  // Control FSM plus last-result, change-pulse and sticky illegal registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_res_q   <= 3'b000;
      last_valid_q <= 1'b0;
      change_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (clear) begin
      state_q      <= freeze ? FROZEN : IDLE;
      last_res_q   <= 3'b000;
      last_valid_q <= 1'b0;
      change_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      change_q <= legal_acc_w && last_valid_q && !same_w;
      if (legal_acc_w) begin
        last_res_q   <= code_w;
        last_valid_q <= 1'b1;
      end
      if (illegal_acc_w) begin
        illegal_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (freeze)           state_q <= FROZEN;
          else if (legal_acc_w) state_q <= RUN;
        end
        RUN: begin
          if (freeze) state_q <= FROZEN;
        end
        FROZEN: begin
          if (!freeze) state_q <= last_valid_q ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign last_res     = last_res_q;
  assign last_valid   = last_valid_q;
  assign change_pulse = change_q;
  assign illegal      = illegal_q;

endmodule

`default_nettype wire

// File: doc/cmp_result_tracker.md
Name: cmp_result_tracker

Overview:
- Downstream stage of the 2-bit magnitude comparator.
- Consumes its one-hot {lt,eq,gt} result with a valid strobe.
- Keeps per-class saturating occurrence counters, the last legal result, a same-result streak length, a change pulse and a sticky illegal-code flag.
- Results are readable on the tile outputs/IOs by the top-level wrapper.

Parameters:
- CNT_W, 8: width of each per-class occurrence counter (gt/eq/lt).
- STREAK_W, 4: width of the consecutive-identical-result counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample strobe; the result bits are sampled on a clk edge where in_valid=1.
- in_gt  input  1  comparator A>B.
- in_eq  input  1  comparator A==B.
- in_lt  input  1  comparator A<B.
- clear  input  1  synchronous soft clear of all statistics.
- freeze  input  1  level; while high, samples are ignored and outputs hold.
- last_res  output  3  last legal result, bit2=lt, bit1=eq, bit0=gt.
- last_valid  output  1  at least one legal sample taken since reset/clear.
- gt_cnt  output  CNT_W  count of legal gt samples.
- eq_cnt  output  CNT_W  count of legal eq samples.
- lt_cnt  output  CNT_W  count of legal lt samples.
- streak  output  STREAK_W  length of the current run of identical legal results.
- change_pulse  output  1  one-cycle pulse when an accepted legal result differs from the previous legal result.
- illegal  output  1  sticky; a sampled code was not exactly one-hot.
- state  output  2  FSM state, for debug.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst) and has priority over everything.
- Reset values: all counters 0, last_res=3'b000, last_valid=0, streak=0, change_pulse=0, illegal=0, state=IDLE.
- Outputs are registered. An accepted sample at edge N is visible after edge N; there is no other latency.
- FSM states:
  - IDLE (2'd0): no legal sample yet.
  - RUN (2'd1).
  - FROZEN (2'd2).
- FSM transitions:
  - IDLE->RUN on the first accepted legal sample.
  - IDLE/RUN->FROZEN when freeze=1.
  - FROZEN->RUN when freeze=0 and last_valid=1.
  - FROZEN->IDLE when freeze=0 and last_valid=0.
- Acceptance: a sample is accepted when in_valid=1, state!=FROZEN, freeze=0 and clear=0.
- Legal code is exactly one of gt/eq/lt high (3'b001, 3'b010, 3'b100).
- Legal accepted sample:
  - The matching counter increments, saturating at 2^CNT_W-1 (it holds at max and never wraps).
  - last_res takes the code and last_valid goes to 1.
  - streak: if last_valid=1 and the code equals last_res, streak increments, saturating at 2^STREAK_W-1. Otherwise streak=1.
  - change_pulse=1 for one cycle only if last_valid was already 1 and the code differs from last_res.
- Illegal accepted sample (000, 011, 111, ...):
  - illegal is set to 1 and stays set until clear or rst.
  - No counter changes, last_res and last_valid are unchanged, streak is forced to 0, change_pulse stays 0.
- change_pulse is 0 in every cycle without a qualifying legal sample.
- clear=1: the same effect as reset for all outputs and state, except that while freeze=1 the state goes to FROZEN. clear beats a simultaneous sample, and that sample is dropped.
- freeze asserted in the same cycle as in_valid: the sample is dropped. freeze has no effect on clear.
- Reset mid-run: all statistics are lost and the block returns to IDLE on the next edge.

Optional Feature:
- Macro CMP_TRACKER_TOTAL_EN.
- With the macro defined: adds output total_cnt, width CNT_W+2. It counts every accepted sample, legal or illegal, saturates at max, and is cleared by rst/clear.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package cmp_tracker_pkg holds:
  - Result encodings RES_GT=3'b001, RES_EQ=3'b010, RES_LT=3'b100.
  - The FSM state encoding (IDLE, RUN, FROZEN).
  - A function is_onehot3.
- One sub-module, sat_counter: parameter W, with inc and clr inputs and a saturating count output. It is instantiated for gt/eq/lt, streak and the optional total.

Test Plan:
- rst, then gt, gt, gt, eq (in_valid each cycle) -> gt_cnt=3, eq_cnt=1, streak=1, last_res=3'b010, change_pulse high only after the 4th sample, state=RUN.
- 300 consecutive eq samples with CNT_W=8, STREAK_W=4 -> eq_cnt=255, streak=15, no change_pulse, no wrap.
- Codes 3'b011 then 3'b000 with in_valid -> illegal=1 and stays 1, all counts unchanged, streak=0, last_valid unchanged. Next legal lt -> lt_cnt+1, streak=1, illegal still 1.
- freeze=1 for 5 cycles with in_valid=1 and lt -> no counter change, state=FROZEN. freeze=0 -> RUN if last_valid=1, else IDLE.
- clear and in_valid(gt) in the same cycle after 10 samples -> every counter 0, last_valid=0, illegal=0, state=IDLE, and the gt sample is not counted.
- With CMP_TRACKER_TOTAL_EN: 4 legal + 2 illegal samples -> total_cnt=6. rst mid-sequence -> total_cnt=0 on the next edge.
